// File: rtl/acl2_pkg.sv
// Shared constants, FSM state type and the per-state SPI transaction descriptor
// for the ADXL362 sequencer.
package acl2_pkg;

    localparam logic [1:0] OP_REG_READ  = 2'b00;
    localparam logic [1:0] OP_FIFO_READ = 2'b01;
    localparam logic [1:0] OP_WRITE     = 2'b10;

    localparam logic [7:0] XDATA      = 8'h08;
    localparam logic [7:0] YDATA      = 8'h09;
    localparam logic [7:0] ZDATA      = 8'h0A;
    localparam logic [7:0] SOFT_RESET = 8'h1F;
    localparam logic [7:0] POWER_CTL  = 8'h2D;

    localparam logic [7:0] SOFT_RESET_KEY = 8'h52;
    localparam logic [7:0] MEASURE_MODE   = 8'h02;

    typedef enum logic [3:0] {
        WAIT_EN,
        CFG_SOFTRST,
        CFG_SRWAIT,
        CFG_MEAS,
        IDLE,
        RD_X,
        RD_Y,
        RD_Z,
        PUBLISH
    } acl2_state_e;

    typedef struct packed {
        logic       req;
        logic [1:0] op;
        logic [7:0] addr;
        logic [7:0] wdata;
    } acl2_xfer_t;

    // Which SPI transaction (if any) a state owns.
    function automatic acl2_xfer_t xfer_for(input acl2_state_e st);
        acl2_xfer_t x;
        x.req   = 1'b1;
        x.op    = OP_REG_READ;
        x.addr  = 8'h00;
        x.wdata = 8'h00;
        case (st)
            CFG_SOFTRST: begin
                x.op    = OP_WRITE;
                x.addr  = SOFT_RESET;
                x.wdata = SOFT_RESET_KEY;
            end
            CFG_MEAS: begin
                x.op    = OP_WRITE;
                x.addr  = POWER_CTL;
                x.wdata = MEASURE_MODE;
            end
            RD_X:    x.addr = XDATA;
            RD_Y:    x.addr = YDATA;
            RD_Z:    x.addr = ZDATA;
            default: x.req  = 1'b0;
        endcase
        return x;
    endfunction

endpackage

// File: rtl/acl2_if.sv
// Request/response bundle between the sequencer (master) and the SPI
// transaction engine (slave).
interface acl2_if;
    logic       SPI_START;
    logic [1:0] SPI_OP;
    logic [7:0] SPI_ADDR;
    logic [7:0] SPI_WDATA;
    logic       SPI_BUSY;
    logic       SPI_DONE;
    logic [7:0] SPI_RDATA;

    modport master (
        output SPI_START, SPI_OP, SPI_ADDR, SPI_WDATA,
        input  SPI_BUSY, SPI_DONE, SPI_RDATA
    );

    modport slave (
        input  SPI_START, SPI_OP, SPI_ADDR, SPI_WDATA,
        output SPI_BUSY, SPI_DONE, SPI_RDATA
    );
endinterface

// File: rtl/acl2_cycle_timer.sv
// Saturating down-counter: load_i presets LOAD_VAL, count_i decrements toward
// zero, expired_o is high while the count sits at zero.
module acl2_cycle_timer #(
    parameter int unsigned LOAD_VAL = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic count_i,
    output logic expired_o
);
    localparam int unsigned W = (LOAD_VAL > 0) ? $clog2(LOAD_VAL + 1) : 1;

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = W'(LOAD_VAL);
        end else if (count_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign expired_o = (cnt_q == '0);
endmodule

// File: rtl/acl2_sequencer.sv
// ADXL362 bring-up and periodic XYZ burst reader on top of a byte-level SPI
// engine, with a per-transaction watchdog that forces re-configuration.
module acl2_sequencer
    import acl2_pkg::*;
#(
    parameter int unsigned SAMPLE_PERIOD  = 1_000_000,
    parameter int unsigned SOFTRST_WAIT   = 50_000,
    parameter int unsigned TIMEOUT_CYCLES = 200_000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       ENABLE,
    acl2_if.master     spi,
    output logic [7:0] X_DATA,
    output logic [7:0] Y_DATA,
    output logic [7:0] Z_DATA,
    output logic       SAMPLE_VALID,
    output logic       CONFIGURED,
    output logic       TIMEOUT_ERR
);
    acl2_state_e state_q, state_d;
    logic        start_q, start_d, pend_q, pend_d;
    logic [1:0]  op_q, op_d;
    logic [7:0]  addr_q, addr_d, wdata_q, wdata_d;
    logic [7:0]  sx_q, sx_d, sy_q, sy_d;
    logic [7:0]  x_q, x_d, y_q, y_d, z_q, z_d;
    logic        valid_q, valid_d, cfg_q, cfg_d, terr_q, terr_d;
    logic        smp_load, smp_count, smp_exp, sr_load, sr_exp, tmo_exp;
    logic        done, issue;
    acl2_xfer_t  xfer;

    assign xfer  = xfer_for(state_q);
    assign done  = pend_q && spi.SPI_DONE;
    assign issue = xfer.req && !pend_q && !spi.SPI_BUSY;
    // The sample period freezes only while parked in IDLE with sampling disabled.
    assign smp_count = !((state_q == IDLE) && !ENABLE);

    acl2_cycle_timer #(.LOAD_VAL(SAMPLE_PERIOD - 1)) u_smp_tmr (
        .clk_i(CLK), .rst_i(RST), .load_i(smp_load), .count_i(smp_count), .expired_o(smp_exp)
    );
    acl2_cycle_timer #(.LOAD_VAL(SOFTRST_WAIT - 1)) u_sr_tmr (
        .clk_i(CLK), .rst_i(RST), .load_i(sr_load), .count_i(1'b1), .expired_o(sr_exp)
    );
    acl2_cycle_timer #(.LOAD_VAL(TIMEOUT_CYCLES)) u_tmo_tmr (
        .clk_i(CLK), .rst_i(RST), .load_i(issue), .count_i(pend_q), .expired_o(tmo_exp)
    );

    always_comb begin
        state_d  = state_q;
        start_d  = 1'b0;
        pend_d   = pend_q;
        op_d     = op_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        sx_d     = sx_q;
        sy_d     = sy_q;
        x_d      = x_q;
        y_d      = y_q;
        z_d      = z_q;
        valid_d  = 1'b0;
        cfg_d    = cfg_q;
        terr_d   = terr_q;
        smp_load = 1'b0;
        sr_load  = 1'b0;

        if (issue) begin
            start_d = 1'b1;
            pend_d  = 1'b1;
            op_d    = xfer.op;
            addr_d  = xfer.addr;
            wdata_d = xfer.wdata;
        end

        case (state_q)
            WAIT_EN:     if (ENABLE) state_d = CFG_SOFTRST;
            CFG_SOFTRST: if (done) begin
                sr_load = 1'b1;
                state_d = CFG_SRWAIT;
            end
            CFG_SRWAIT:  if (sr_exp) state_d = CFG_MEAS;
            CFG_MEAS:    if (done) begin
                cfg_d    = 1'b1;
                smp_load = 1'b1;
                state_d  = IDLE;
            end
            IDLE:        if (ENABLE && smp_exp) begin
                smp_load = 1'b1;
                state_d  = RD_X;
            end
            RD_X:        if (done) begin
                sx_d    = spi.SPI_RDATA;
                state_d = RD_Y;
            end
            RD_Y:        if (done) begin
                sy_d    = spi.SPI_RDATA;
                state_d = RD_Z;
            end
            // Publish straight from the Z completion so outputs move one cycle after DONE.
            RD_Z:        if (done) begin
                x_d     = sx_q;
                y_d     = sy_q;
                z_d     = spi.SPI_RDATA;
                valid_d = 1'b1;
                state_d = PUBLISH;
            end
            PUBLISH:     state_d = IDLE;
            default:     state_d = WAIT_EN;
        endcase

        if (done) begin
            pend_d = 1'b0;
        end else if (pend_q && tmo_exp) begin
            pend_d  = 1'b0;
            terr_d  = 1'b1;
            cfg_d   = 1'b0;
            state_d = CFG_SOFTRST;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= WAIT_EN;
            start_q <= 1'b0;
            pend_q  <= 1'b0;
            op_q    <= 2'b00;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            sx_q    <= 8'h00;
            sy_q    <= 8'h00;
            x_q     <= 8'h00;
            y_q     <= 8'h00;
            z_q     <= 8'h00;
            valid_q <= 1'b0;
            cfg_q   <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            pend_q  <= pend_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            valid_q <= valid_d;
            cfg_q   <= cfg_d;
            terr_q  <= terr_d;
        end
    end

    assign spi.SPI_START = start_q;
    assign spi.SPI_OP    = op_q;
    assign spi.SPI_ADDR  = addr_q;
    assign spi.SPI_WDATA = wdata_q;
    assign X_DATA        = x_q;
    assign Y_DATA        = y_q;
    assign Z_DATA        = z_q;
    assign SAMPLE_VALID  = valid_q;
    assign CONFIGURED    = cfg_q;
    assign TIMEOUT_ERR   = terr_q;
endmodule

// File: tb/tb_acl2_sequencer.sv
// Directed bench: behavioural SPI engine with programmable latency plus
// hand-computed expectations for bring-up, bursts, stalls and faults.
module tb_acl2_sequencer;
    import acl2_pkg::*;

    localparam int unsigned SP  = 500;
    localparam int unsigned SW  = 100;
    localparam int unsigned TO  = 300;
    localparam int          LAT = 40;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       ENABLE = 1'b0;
    logic [7:0] X_DATA, Y_DATA, Z_DATA;
    logic       SAMPLE_VALID, CONFIGURED, TIMEOUT_ERR;

    logic       eng_busy = 1'b0, eng_done = 1'b0, force_busy = 1'b0, drop_y = 1'b0;
    logic [7:0] eng_rdata = 8'h00, rx = 8'h00, ry = 8'h00, rz = 8'h00;
    int         lat_y = LAT;
    bit         eng_pend = 1'b0;
    int         cyc = 0, n_start = 0, n_valid = 0, valid_cyc = 0, stab_err = 0, n_fifo = 0;
    int         cur = 0, eng_cnt = 0, last_y = 0;
    int         n_chk = 0, n_pass = 0;

    logic [1:0] t_op    [0:511];
    logic [7:0] t_addr  [0:511];
    logic [7:0] t_wdata [0:511];
    int         t_scyc  [0:511];
    int         t_dcyc  [0:511];

    acl2_if spi_bus ();
    assign spi_bus.SPI_BUSY  = eng_busy | force_busy;
    assign spi_bus.SPI_DONE  = eng_done;
    assign spi_bus.SPI_RDATA = eng_rdata;

    acl2_sequencer #(.SAMPLE_PERIOD(SP), .SOFTRST_WAIT(SW), .TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .spi(spi_bus.master),
        .X_DATA(X_DATA), .Y_DATA(Y_DATA), .Z_DATA(Z_DATA),
        .SAMPLE_VALID(SAMPLE_VALID), .CONFIGURED(CONFIGURED), .TIMEOUT_ERR(TIMEOUT_ERR)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Engine model and transaction log, evaluated mid-cycle.
    always @(negedge CLK) begin
        if (RST) begin
            eng_pend = 1'b0;
            eng_busy = 1'b0;
            eng_done = 1'b0;
        end else begin
            eng_done = 1'b0;
            if (eng_pend) begin
                if (spi_bus.SPI_OP !== t_op[cur] || spi_bus.SPI_ADDR !== t_addr[cur] ||
                    spi_bus.SPI_WDATA !== t_wdata[cur]) stab_err++;
                eng_cnt--;
                if (eng_cnt == 0) begin
                    eng_done = 1'b1;
                    eng_busy = 1'b0;
                    eng_pend = 1'b0;
                    t_dcyc[cur] = cyc;
                    case (t_addr[cur])
                        8'h08:   eng_rdata = rx;
                        8'h09:   eng_rdata = ry;
                        8'h0A:   eng_rdata = rz;
                        default: eng_rdata = 8'h00;
                    endcase
                end
            end
            if (spi_bus.SPI_START && n_start < 512) begin
                t_op[n_start]    = spi_bus.SPI_OP;
                t_addr[n_start]  = spi_bus.SPI_ADDR;
                t_wdata[n_start] = spi_bus.SPI_WDATA;
                t_scyc[n_start]  = cyc;
                if (spi_bus.SPI_OP == OP_FIFO_READ) n_fifo++;
                if (spi_bus.SPI_ADDR == 8'h09) last_y = n_start;
                if (!(drop_y && spi_bus.SPI_ADDR == 8'h09)) begin
                    eng_pend = 1'b1;
                    eng_busy = 1'b1;
                    cur      = n_start;
                    eng_cnt  = (spi_bus.SPI_ADDR == 8'h09) ? lat_y : LAT;
                end
                n_start++;
            end
            if (SAMPLE_VALID) begin
                n_valid++;
                valid_cyc = cyc;
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic wait_start(input int budget, output bit ok);
        int base;
        base = n_start;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if (n_start != base) ok = 1'b1;
        end
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        int base;
        base = n_valid;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if (n_valid != base) ok = 1'b1;
        end
    endtask

    task automatic wait_cfg(input int budget, output bit ok);
        ok = CONFIGURED;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if (CONFIGURED) ok = 1'b1;
        end
    endtask

    task automatic wait_addr_start(input logic [7:0] a, input int budget, output bit ok);
        int base;
        base = n_start;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if (n_start != base && t_addr[n_start-1] == a) ok = 1'b1;
        end
    endtask

    initial begin
        bit ok;
        int b1, b2, base, target, f;

        repeat (3) tick();
        RST = 1'b0;
        tick();
        check_val("rst_start", spi_bus.SPI_START, 0);
        check_val("rst_op", spi_bus.SPI_OP, 0);
        check_val("rst_addr", spi_bus.SPI_ADDR, 0);
        check_val("rst_wdata", spi_bus.SPI_WDATA, 0);
        check_val("rst_xyz", {X_DATA, Y_DATA, Z_DATA}, 0);
        check_val("rst_flags", {SAMPLE_VALID, CONFIGURED, TIMEOUT_ERR}, 0);
        repeat (20) tick();
        check_val("wait_en_hold", n_start, 0);

        // Bring-up
        ENABLE = 1'b1;
        wait_cfg(2000, ok);
        check_val("cfg_reached", ok, 1);
        check_val("cfg_xfer_count", n_start, 2);
        check_val("cfg_softrst", {t_op[0], t_addr[0], t_wdata[0]}, {2'b10, 8'h1F, 8'h52});
        check_val("cfg_meas", {t_op[1], t_addr[1], t_wdata[1]}, {2'b10, 8'h2D, 8'h02});
        f = t_scyc[1] - t_dcyc[0];
        check_val("srwait_gap_ok", (f >= int'(SW) && f <= int'(SW) + 10), 1);

        // First burst
        rx = 8'h11; ry = 8'h22; rz = 8'h33;
        wait_valid(1000, ok);
        check_val("burst1_valid", ok, 1);
        b1 = n_start - 3;
        check_val("burst1_addrs", {t_addr[b1], t_addr[b1+1], t_addr[b1+2]}, 24'h08090A);
        check_val("burst1_ops", {t_op[b1], t_op[b1+1], t_op[b1+2], t_wdata[b1], t_wdata[b1+1], t_wdata[b1+2]}, 0);
        check_val("burst1_xyz", {X_DATA, Y_DATA, Z_DATA}, 24'h112233);
        check_val("publish_latency", valid_cyc, t_dcyc[b1+2] + 1);
        tick();
        check_val("valid_pulse_width", SAMPLE_VALID, 0);

        // Second burst, spacing
        rx = 8'h44; ry = 8'h55; rz = 8'h66;
        wait_valid(1000, ok);
        check_val("burst2_valid", ok, 1);
        b2 = n_start - 3;
        check_val("burst2_xyz", {X_DATA, Y_DATA, Z_DATA}, 24'h445566);
        check_val("burst_spacing", t_scyc[b2] - t_scyc[b1], SP);

        // Engine busy across the next request
        target = t_scyc[b2] + int'(SP);
        while (cyc < target - 50) tick();
        force_busy = 1'b1;
        base = n_start;
        while (cyc < target + 50) tick();
        check_val("busy_no_start", n_start, base);
        force_busy = 1'b0;
        f = cyc;
        wait_start(20, ok);
        check_val("busy_start_seen", ok, 1);
        check_val("busy_start_delay", t_scyc[base], f + 1);
        check_val("busy_start_addr", t_addr[base], 8'h08);
        wait_valid(500, ok);
        check_val("busy_burst_valid", ok, 1);

        // ENABLE dropped during RD_X
        rx = 8'h5A; ry = 8'h6B; rz = 8'h7C;
        wait_addr_start(8'h08, 1000, ok);
        check_val("en_drop_rdx_seen", ok, 1);
        ENABLE = 1'b0;
        wait_valid(500, ok);
        check_val("en_drop_publish", ok, 1);
        check_val("en_drop_xyz", {X_DATA, Y_DATA, Z_DATA}, 24'h5A6B7C);
        base = n_start;
        repeat (1200) tick();
        check_val("en_low_no_burst", n_start, base);
        check_val("en_low_cfg_held", CONFIGURED, 1);
        ENABLE = 1'b1;
        wait_start(600, ok);
        check_val("en_resume_start", ok, 1);
        check_val("en_resume_addr", t_addr[n_start-1], 8'h08);
        wait_valid(500, ok);

        // Timeout on RD_Y
        rx = 8'h77; ry = 8'h88; rz = 8'h99;
        drop_y = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 1500 && !ok; i++) begin
            tick();
            if (TIMEOUT_ERR) ok = 1'b1;
        end
        check_val("timeout_seen", ok, 1);
        check_val("timeout_latency", cyc, t_scyc[last_y] + int'(TO) + 1);
        check_val("timeout_cfg_clr", CONFIGURED, 0);
        check_val("timeout_keeps_xyz", {X_DATA, Y_DATA, Z_DATA}, 24'h5A6B7C);
        drop_y = 1'b0;
        wait_start(20, ok);
        check_val("timeout_reinit_seen", ok, 1);
        check_val("timeout_reinit_xfer", {t_op[n_start-1], t_addr[n_start-1], t_wdata[n_start-1]},
                  {2'b10, 8'h1F, 8'h52});
        wait_cfg(2000, ok);
        check_val("timeout_recfg", ok, 1);
        wait_valid(1000, ok);
        check_val("recover_valid", ok, 1);
        check_val("recover_xyz", {X_DATA, Y_DATA, Z_DATA}, 24'h778899);
        check_val("timeout_sticky", TIMEOUT_ERR, 1);

        // Reset during RD_Z
        wait_addr_start(8'h0A, 1000, ok);
        check_val("rst_rdz_seen", ok, 1);
        RST = 1'b1;
        tick();
        check_val("midrst_spi", {spi_bus.SPI_START, spi_bus.SPI_OP, spi_bus.SPI_ADDR, spi_bus.SPI_WDATA}, 0);
        check_val("midrst_xyz", {X_DATA, Y_DATA, Z_DATA}, 0);
        check_val("midrst_flags", {SAMPLE_VALID, CONFIGURED, TIMEOUT_ERR}, 0);
        ENABLE = 1'b0;
        RST = 1'b0;
        base = n_start;
        repeat (50) tick();
        check_val("midrst_wait_en", n_start, base);
        ENABLE = 1'b1;
        wait_start(20, ok);
        check_val("midrst_restart", ok, 1);
        check_val("midrst_first_addr", t_addr[n_start-1], 8'h1F);

        // DONE exactly at timeout expiry
        lat_y = TO;
        rx = 8'hA1; ry = 8'hB2; rz = 8'hC3;
        wait_cfg(2000, ok);
        check_val("coinc_cfg", ok, 1);
        wait_valid(1200, ok);
        check_val("coinc_valid", ok, 1);
        check_val("coinc_no_err", TIMEOUT_ERR, 0);
        check_val("coinc_xyz", {X_DATA, Y_DATA, Z_DATA}, 24'hA1B2C3);
        check_val("coinc_cfg_held", CONFIGURED, 1);

        check_val("spi_hold_stable", stab_err, 0);
        check_val("fifo_op_unused", n_fifo, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/acl2_sequencer.md
# acl2_sequencer

Sequencer for the ACL2 (ADXL362) accelerometer SPI path. Owns the byte-level SPI transaction engine: after reset it soft-resets the sensor and puts it in measurement mode, then periodically reads the X, Y and Z 8-bit data registers as one burst. It publishes the three values atomically to downstream logic and watches every transaction with a timeout. Sits between the SPI transaction engine and the application/display logic.

## Interface
Parameters:
- SAMPLE_PERIOD, 1_000_000: CLK cycles between burst starts (100 Hz at 100 MHz).
- SOFTRST_WAIT, 50_000: CLK cycles to wait after the soft-reset write.
- TIMEOUT_CYCLES, 200_000: max CLK cycles from SPI_START to SPI_DONE.

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset, synchronous, active-high.
- ENABLE  in  1  permits configuration and sampling.
- SPI_START  out  1  one-cycle transaction request.
- SPI_OP  out  2  00 reg read, 01 FIFO read (unused), 10 write.
- SPI_ADDR  out  8  register address.
- SPI_WDATA  out  8  write data (0 for reads).
- SPI_BUSY  in  1  engine busy.
- SPI_DONE  in  1  one-cycle completion pulse.
- SPI_RDATA  in  8  read byte, valid with SPI_DONE.
- X_DATA, Y_DATA, Z_DATA  out  8 each  latest sample.
- SAMPLE_VALID  out  1  one-cycle pulse on publish.
- CONFIGURED  out  1  sensor in measurement mode.
- TIMEOUT_ERR  out  1  sticky timeout flag.

## Operation
- States: WAIT_EN, CFG_SOFTRST, CFG_SRWAIT, CFG_MEAS, IDLE, RD_X, RD_Y, RD_Z, PUBLISH.
- WAIT_EN: stay until ENABLE=1, then go to CFG_SOFTRST.
- CFG_SOFTRST: write 0x52 to 0x1F. On completion go to CFG_SRWAIT.
- CFG_SRWAIT: wait SOFTRST_WAIT cycles, then go to CFG_MEAS.
- CFG_MEAS: write 0x02 to POWER_CTL 0x2D. On completion set CONFIGURED=1, load the sample timer and go to IDLE.
- IDLE: on timer expiry with ENABLE=1, reload the timer and go to RD_X.
- IDLE with ENABLE=0: the timer holds and no burst starts. CONFIGURED stays 1.
- RD_X, RD_Y, RD_Z: reg read of 0x08, 0x09, 0x0A in turn. Each byte is captured into a shadow register on SPI_DONE.
- PUBLISH: copy the shadows to X/Y/Z_DATA, pulse SAMPLE_VALID and return to IDLE.
- ENABLE deasserted mid-burst: the burst completes and publishes. Only the next burst is blocked.
- Per-transaction step: wait for SPI_BUSY=0, then pulse SPI_START. Hold OP/ADDR/WDATA stable until SPI_DONE. Advance on SPI_DONE.
- Timeout: TIMEOUT_CYCLES elapse after SPI_START with no SPI_DONE:
  - set TIMEOUT_ERR (cleared only by RST);
  - clear CONFIGURED;
  - discard the shadows; X/Y/Z_DATA keep their old values;
  - go to CFG_SOFTRST.
- SPI_DONE and timeout expiry in the same cycle: SPI_DONE wins and no error is raised.
- SPI_DONE arriving with no transaction outstanding is ignored.
- Reset values: SPI_START=0, SPI_OP=00, SPI_ADDR=0, SPI_WDATA=0, X/Y/Z_DATA=0, SAMPLE_VALID=0, CONFIGURED=0, TIMEOUT_ERR=0, state WAIT_EN, all timers cleared.
- RST mid-operation aborts immediately. The SPI engine shares RST.

## Timing
- All outputs are registered.
- SPI_START rises one cycle after entering a transaction state with SPI_BUSY=0. If SPI_BUSY=1, it rises on the first cycle after BUSY falls.
- The next SPI_START comes no earlier than one cycle after the previous SPI_DONE.
- Sample timer counts from 0 to SAMPLE_PERIOD-1 and wraps. Burst start-to-start spacing is exactly SAMPLE_PERIOD cycles.
- If a burst outlasts SAMPLE_PERIOD, the next burst starts immediately from IDLE. Missed ticks are not queued.
- X/Y/Z_DATA change in the same cycle SAMPLE_VALID=1, which is one cycle after the RD_Z SPI_DONE.
- Counter widths are $clog2(max parameter + 1). There is no arithmetic on data bytes.

## Structure
- Package acl2_pkg holds:
  - op encodings: OP_REG_READ=2'b00, OP_FIFO_READ=2'b01, OP_WRITE=2'b10;
  - addresses: XDATA 0x08, YDATA 0x09, ZDATA 0x0A, SOFT_RESET 0x1F, POWER_CTL 0x2D;
  - values: SOFT_RESET_KEY 0x52, MEASURE_MODE 0x02;
  - the state enum.
- One sub-module, acl2_cycle_timer: parameterised load/count/expire counter. Three instances cover the sample period, soft-reset wait and transaction timeout.

## Test plan
- Reset, ENABLE=1, engine model with 40-cycle DONE latency → writes (0x1F,0x52), wait ≥ SOFTRST_WAIT, then (0x2D,0x02) → CONFIGURED=1.
- Model returns 0x11/0x22/0x33 → X/Y/Z_DATA=0x11/0x22/0x33 with one SAMPLE_VALID pulse. Bursts start exactly SAMPLE_PERIOD apart (use SAMPLE_PERIOD=500 in sim).
- Model withholds DONE on RD_Y → TIMEOUT_ERR=1 after TIMEOUT_CYCLES, CONFIGURED=0, old X/Y/Z kept, new soft-reset write issued.
- SPI_BUSY held high 100 cycles at a request → SPI_START delayed until BUSY falls. ADDR/OP stay stable until DONE.
- ENABLE dropped during RD_X → burst completes and publishes, then no further SPI_START until ENABLE=1.
- RST pulsed during RD_Z → all outputs return to reset values next cycle and state is WAIT_EN.
- DONE coincident with timeout expiry → no TIMEOUT_ERR and the sequence advances.
